// File: rtl/seq_divider_4bit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider_4bit_if : start/busy/done handshake bundle for the       |
// |                       sequential divider                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seq_divider_4bit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             div_by_zero;

  modport master (
    output start, Dividend, Divisor,
    input  busy, done, Quotient, Remainder, div_by_zero
  );

  modport slave (
    input  start, Dividend, Divisor,
    output busy, done, Quotient, Remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider_4bit : restoring shift-and-subtract divider, one step    |
// |                    per clock. Option macro: DIV_ZERO_FAST_EN         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_divider_4bit #(
  parameter int WIDTH = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  seq_divider_4bit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;    // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic             w_dvs_zero;

  // Stored remainder is always below the divisor, so WIDTH bits suffice;
  // the shifted and trial values need the extra bit.
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_rem_sh + ~{1'b0, r_dvs} + {{WIDTH{1'b0}}, 1'b1};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_dvs_zero = (r_dvs == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_dvd   <= bus.Dividend;
            r_dvs   <= bus.Divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
`ifdef DIV_ZERO_FAST_EN
          if (w_dvs_zero) begin
            r_quo   <= '1;
            r_rmd   <= r_dvd;
            r_dz    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else
`endif
          if (r_cnt == CNT_W'(WIDTH)) begin
            r_quo   <= r_dvd;
            r_rmd   <= r_rem;
            r_dz    <= w_dvs_zero;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_rem <= w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.Quotient    = r_quo;
  assign bus.Remainder   = r_rmd;
  assign bus.div_by_zero = r_dz;
endmodule
`default_nettype wire
